// File: rtl/uart_pkg.sv
// Shared types and trigger-level constants for the UART receive path.
package uart_pkg;

  typedef struct packed {
    logic       bi;
    logic       fe;
    logic       pe;
    logic [7:0] data;
  } rx_entry_t;

  typedef enum logic [1:0] {
    TRIG_1  = 2'b00,
    TRIG_4  = 2'b01,
    TRIG_8  = 2'b10,
    TRIG_14 = 2'b11
  } rx_trig_t;

  localparam int TRIG_LVL_1  = 1;
  localparam int TRIG_LVL_4  = 4;
  localparam int TRIG_LVL_8  = 8;
  localparam int TRIG_LVL_14 = 14;

  function automatic int trigLevel(input rx_trig_t code);
    int lvl;
    case (code)
      TRIG_1:  lvl = TRIG_LVL_1;
      TRIG_4:  lvl = TRIG_LVL_4;
      TRIG_8:  lvl = TRIG_LVL_8;
      default: lvl = TRIG_LVL_14;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Register array for the receive FIFO: synchronous write, asynchronous head read.
// Deliberately unreset; occupancy and pointers live in uart_rx_fifo.
module uart_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int W     = 11
) (
  input  logic                     clock,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] wAddr,
  input  logic [W-1:0]             wData,
  input  logic [$clog2(DEPTH)-1:0] rAddr,
  output logic [W-1:0]             rData
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[wAddr] <= wData;
  end

  assign rData = mem[rAddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO (first-word-fall-through) with overrun, error summary and count.
// Optional RCLVL/TRIGGER threshold logic when UART_RX_FIFO_TRIGGER_EN is defined.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int DW    = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          CLEAR,
  input  logic          WE,
  input  logic [DW-1:0] DIN,
  input  logic          PE_IN,
  input  logic          FE_IN,
  input  logic          BI_IN,
  input  logic          RE,
  input  logic          OVR_CLR,
  output logic [DW-1:0] DOUT,
  output logic          PE,
  output logic          FE,
  output logic          BI,
  output logic          EMPTY,
  output logic          FULL,
  output logic [CW-1:0] COUNT,
  output logic          OVERRUN,
  output logic          FIFOERR
`ifdef UART_RX_FIFO_TRIGGER_EN
  ,
  input  logic [1:0]    RCLVL,
  output logic          TRIGGER
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = DW + 3;

  logic [AW-1:0] wrPtr, rdPtr;
  logic [CW-1:0] count, countNext, errCount, errCountNext;
  logic [EW-1:0] headEntry, wrEntry;
  logic          overrun, isEmpty, isFull;
  logic          doWrite, doRead, overrunSet, wrErr, rdErr, memWe;

  assign isEmpty = (count == '0);
  assign isFull  = (count == CW'(DEPTH));
  assign wrEntry = {BI_IN, FE_IN, PE_IN, DIN};

  // A full FIFO still accepts a write when the head is popped in the same cycle.
  always_comb begin
    doWrite      = WE && (!isFull || RE);
    doRead       = RE && !isEmpty;
    overrunSet   = WE && isFull && !RE;
    wrErr        = doWrite && (PE_IN || FE_IN || BI_IN);
    rdErr        = doRead && (|headEntry[DW+2:DW]);
    memWe        = doWrite && !RST && !CLEAR;
    countNext    = count;
    errCountNext = errCount;
    if (doWrite && !doRead) countNext = count + CW'(1);
    if (doRead && !doWrite) countNext = count - CW'(1);
    if (wrErr && !rdErr) errCountNext = errCount + CW'(1);
    if (rdErr && !wrErr) errCountNext = errCount - CW'(1);
  end

  uart_fifo_mem #(.DEPTH(DEPTH), .W(EW)) uMem (
    .clock (CLK),
    .we    (memWe),
    .wAddr (wrPtr),
    .wData (wrEntry),
    .rAddr (rdPtr),
    .rData (headEntry)
  );

  always_ff @(posedge CLK) begin
    if (RST || CLEAR) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      errCount <= '0;
    end else begin
      if (doWrite) wrPtr <= wrPtr + AW'(1);
      if (doRead)  rdPtr <= rdPtr + AW'(1);
      count    <= countNext;
      errCount <= errCountNext;
    end
  end

  // Overrun survives CLEAR; a new overrun beats a simultaneous OVR_CLR.
  always_ff @(posedge CLK) begin
    if (RST)                      overrun <= 1'b0;
    else if (!CLEAR && overrunSet) overrun <= 1'b1;
    else if (OVR_CLR)             overrun <= 1'b0;
  end

  assign DOUT    = isEmpty ? '0 : headEntry[DW-1:0];
  assign PE      = !isEmpty && headEntry[DW];
  assign FE      = !isEmpty && headEntry[DW+1];
  assign BI      = !isEmpty && headEntry[DW+2];
  assign EMPTY   = isEmpty;
  assign FULL    = isFull;
  assign COUNT   = count;
  assign OVERRUN = overrun;
  assign FIFOERR = (errCount != '0);

`ifdef UART_RX_FIFO_TRIGGER_EN
  logic trigReg;
  int   trigLvl;

  always_comb begin
    trigLvl = trigLevel(rx_trig_t'(RCLVL));
    if (trigLvl > DEPTH) trigLvl = DEPTH;
  end

  always_ff @(posedge CLK) begin
    if (RST || CLEAR) trigReg <= 1'b0;
    else              trigReg <= (int'(countNext) >= trigLvl);
  end

  assign TRIGGER = trigReg;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized self-checking bench for uart_rx_fifo against a queue-based reference model.
// Exercises RCLVL/TRIGGER too when UART_RX_FIFO_TRIGGER_EN is defined.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int DEPTH = 16;
  localparam int DW    = 8;
  localparam int CW    = 5;

  logic          CLK = 1'b0;
  logic          RST, CLEAR, WE, PE_IN, FE_IN, BI_IN, RE, OVR_CLR;
  logic [DW-1:0] DIN;
  logic [DW-1:0] DOUT;
  logic          PE, FE, BI, EMPTY, FULL, OVERRUN, FIFOERR;
  logic [CW-1:0] COUNT;
`ifdef UART_RX_FIFO_TRIGGER_EN
  logic [1:0]    RCLVL;
  logic          TRIGGER;
`endif

  uart_rx_fifo #(.DEPTH(DEPTH), .DW(DW), .CW(CW)) dut (
    .CLK(CLK), .RST(RST), .CLEAR(CLEAR), .WE(WE), .DIN(DIN),
    .PE_IN(PE_IN), .FE_IN(FE_IN), .BI_IN(BI_IN), .RE(RE), .OVR_CLR(OVR_CLR),
    .DOUT(DOUT), .PE(PE), .FE(FE), .BI(BI), .EMPTY(EMPTY), .FULL(FULL),
    .COUNT(COUNT), .OVERRUN(OVERRUN), .FIFOERR(FIFOERR)
`ifdef UART_RX_FIFO_TRIGGER_EN
    , .RCLVL(RCLVL), .TRIGGER(TRIGGER)
`endif
  );

  always #5 CLK = ~CLK;

  rx_entry_t modelQ[$];
  bit        modelOvr;
  int        testsRun;
  int        testsFailed;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit modelErr();
    foreach (modelQ[i]) if (modelQ[i].pe || modelQ[i].fe || modelQ[i].bi) return 1'b1;
    return 1'b0;
  endfunction

  task automatic checkState();
    rx_entry_t head;
    head = (modelQ.size() > 0) ? modelQ[0] : rx_entry_t'(0);
    checkOutput("dout",    32'(DOUT),    32'(head.data));
    checkOutput("pe",      32'(PE),      32'(head.pe));
    checkOutput("fe",      32'(FE),      32'(head.fe));
    checkOutput("bi",      32'(BI),      32'(head.bi));
    checkOutput("empty",   32'(EMPTY),   32'(modelQ.size() == 0));
    checkOutput("full",    32'(FULL),    32'(modelQ.size() == DEPTH));
    checkOutput("count",   32'(COUNT),   32'(modelQ.size()));
    checkOutput("overrun", 32'(OVERRUN), 32'(modelOvr));
    checkOutput("fifoerr", 32'(FIFOERR), 32'(modelErr()));
`ifdef UART_RX_FIFO_TRIGGER_EN
    begin
      int lvls[4] = '{1, 4, 8, 14};
      int lvl;
      lvl = (lvls[RCLVL] > DEPTH) ? DEPTH : lvls[RCLVL];
      checkOutput("trigger", 32'(TRIGGER), 32'(modelQ.size() >= lvl));
    end
`endif
  endtask

  // One clock of stimulus; the model applies the same cycle's rules at the edge.
  task automatic applyStimulus(input bit we, input logic [7:0] din, input bit pe, input bit fe,
                               input bit bi, input bit re, input bit clear, input bit ovrClr,
                               input bit rst);
    int  sz;
    bit  wasFull;
    RST = rst; CLEAR = clear; WE = we; DIN = din; PE_IN = pe; FE_IN = fe; BI_IN = bi;
    RE = re; OVR_CLR = ovrClr;
    @(posedge CLK);
    sz      = modelQ.size();
    wasFull = (sz == DEPTH);
    if (rst) begin
      modelQ.delete();
      modelOvr = 1'b0;
    end else if (clear) begin
      modelQ.delete();
      if (ovrClr) modelOvr = 1'b0;
    end else begin
      if (we && wasFull && !re) modelOvr = 1'b1;
      else if (ovrClr)          modelOvr = 1'b0;
      if (re && sz > 0) void'(modelQ.pop_front());
      if (we && (!wasFull || re)) modelQ.push_back({bi, fe, pe, din});
    end
    #1;
    RST = 0; CLEAR = 0; WE = 0; RE = 0; OVR_CLR = 0; PE_IN = 0; FE_IN = 0; BI_IN = 0; DIN = '0;
    checkState();
  endtask

  task automatic pushByte(input logic [7:0] d);
    applyStimulus(1, d, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic popByte();
    applyStimulus(0, 8'h00, 0, 0, 0, 1, 0, 0, 0);
  endtask

  initial begin
    testsRun = 0;
    testsFailed = 0;
    modelOvr = 1'b0;
`ifdef UART_RX_FIFO_TRIGGER_EN
    RCLVL = 2'b01;
`endif
    applyStimulus(0, 8'h00, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 8'h00, 0, 0, 0, 0, 0, 0, 1);

    pushByte(8'h41);
    checkOutput("firstNotEmpty", 32'(EMPTY), 32'd0);
    pushByte(8'h42);
    pushByte(8'h43);
    checkOutput("count3", 32'(COUNT), 32'd3);
    for (int i = 0; i < 3; i++) popByte();
    popByte();

    for (int i = 0; i < DEPTH; i++) pushByte(8'(8'h20 + i));
    pushByte(8'h99);
    checkOutput("ovrSet", 32'(OVERRUN), 32'd1);
    checkOutput("headKept", 32'(DOUT), 32'h20);
    applyStimulus(0, 8'h00, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("ovrClr", 32'(OVERRUN), 32'd0);

    applyStimulus(1, 8'h55, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("fullRw", 32'(COUNT), 32'd16);
    for (int i = 0; i < DEPTH - 1; i++) popByte();
    checkOutput("last55", 32'(DOUT), 32'h55);
    popByte();

    applyStimulus(1, 8'h10, 0, 1, 0, 0, 0, 0, 0);
    pushByte(8'h11);
    checkOutput("errSet", 32'(FIFOERR), 32'd1);
    popByte();
    checkOutput("errGone", 32'(FIFOERR), 32'd0);
    popByte();

    for (int i = 0; i < DEPTH; i++) applyStimulus(1, 8'(i), i[0], 0, i[1], 0, 0, 0, 0);
    pushByte(8'hEE);
    for (int i = 0; i < DEPTH - 5; i++) popByte();
    applyStimulus(1, 8'h77, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("clrCount", 32'(COUNT), 32'd0);
    checkOutput("clrOvrKept", 32'(OVERRUN), 32'd1);
    applyStimulus(1, 8'h66, 0, 0, 0, 1, 0, 0, 0);
    applyStimulus(0, 8'h00, 0, 0, 0, 0, 1, 0, 0);

`ifdef UART_RX_FIFO_TRIGGER_EN
    RCLVL = 2'b01;
    for (int i = 0; i < 3; i++) pushByte(8'(i));
    checkOutput("trig3", 32'(TRIGGER), 32'd0);
    pushByte(8'h03);
    checkOutput("trig4", 32'(TRIGGER), 32'd1);
    popByte();
    checkOutput("trigDrop", 32'(TRIGGER), 32'd0);
`endif

    for (int n = 0; n < 800; n++) begin
      bit clr, oc;
      clr = ($urandom_range(49) == 0);
      oc  = !clr && ($urandom_range(9) == 0);
`ifdef UART_RX_FIFO_TRIGGER_EN
      RCLVL = 2'($urandom_range(3));
`endif
      applyStimulus($urandom_range(99) < 55, 8'($urandom), $urandom_range(7) == 0,
                    $urandom_range(7) == 0, $urandom_range(11) == 0, $urandom_range(99) < 45,
                    clr, oc, $urandom_range(199) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive FIFO sitting directly downstream of the UART receive state machine. It captures each completed character (data plus PE/FE/BI status) on the receiver's one-cycle finish strobe and buffers it for the register interface in first-word-fall-through order. It also provides overrun detection, a per-FIFO error summary and the occupancy count.

Parameters:
DEPTH, 16, number of entries; power of two, 2..256
DW, 8, data width of one character
CW, $clog2(DEPTH)+1, width of COUNT

Ports:
CLK  input  1  system clock
RST  input  1  synchronous reset, active-high
CLEAR  input  1  synchronous FIFO flush (FCR bit), active-high
WE  input  1  write strobe; receiver finish pulse, one cycle per character
DIN  input  DW  received character
PE_IN  input  1  parity error of DIN
FE_IN  input  1  framing error of DIN
BI_IN  input  1  break indication of DIN
RE  input  1  read strobe (RBR read), one cycle per pop
OVR_CLR  input  1  clear sticky overrun (LSR read)
DOUT  output  DW  head character (valid when !EMPTY)
PE  output  1  head parity error
FE  output  1  head framing error
BI  output  1  head break
EMPTY  output  1  no entries
FULL  output  1  COUNT == DEPTH
COUNT  output  CW  occupancy 0..DEPTH
OVERRUN  output  1  sticky: write attempted while full
FIFOERR  output  1  at least one stored entry has PE|FE|BI

Behaviour:
- Reset (RST=1): pointers 0, COUNT=0, EMPTY=1, FULL=0, OVERRUN=0, FIFOERR=0, DOUT=0, PE/FE/BI=0. Storage contents are not reset.
- CLEAR has the same effect as RST, except that OVERRUN is kept.
- RST takes priority over CLEAR; CLEAR takes priority over WE/RE in the same cycle.
- Entry is {BI,FE,PE,DIN}, written at the write pointer on the WE edge.
- Pointers wrap modulo DEPTH.
- First-word-fall-through: the head is visible on DOUT/PE/FE/BI in the cycle after the write that makes the FIFO non-empty (one-cycle write-to-output latency).
- While EMPTY, head outputs are forced to 0.
- RE while EMPTY is ignored: no pointer change, no error.
- WE while FULL and !RE: the character is dropped, storage is unchanged, and OVERRUN is set next cycle.
- WE and RE together while FULL: both occur; COUNT stays DEPTH, no overrun.
- WE and RE together while EMPTY: the write occurs and the read is ignored; COUNT becomes 1.
- WE and RE together otherwise: both occur; COUNT is unchanged.
- OVERRUN is cleared by OVR_CLR or RST. If OVR_CLR and a new overrun occur in the same cycle, the set wins.
- FIFOERR is driven from an internal error-entry counter (width CW):
  - +1 on an accepted write with PE_IN|FE_IN|BI_IN.
  - -1 on a pop of a head with PE|FE|BI.
  - Unchanged when both happen in the same cycle.
  - FIFOERR = counter != 0.
  - Counter is zeroed by RST/CLEAR.
- All outputs are registered or derived from registered state; there is no combinational path from WE/RE to the outputs.

Optional Feature:
- Macro: UART_RX_FIFO_TRIGGER_EN.
- Defined:
  - Adds input RCLVL[1:0] and output TRIGGER.
  - Levels: 00→1, 01→4, 10→8, 11→14 entries.
  - Levels are clamped to DEPTH.
  - TRIGGER = registered (COUNT >= level), updated the same cycle as COUNT.
  - TRIGGER is 0 at reset and after CLEAR.
- Undefined: neither port exists and no trigger logic is built.

Decomposition:
- Package uart_pkg holds:
  - rx_entry_t: packed struct {bi, fe, pe, data[7:0]}.
  - rx_trig_t: enum for the RCLVL codes.
  - The trigger-level constants.
- Sub-module uart_fifo_mem: simple dual-port register array with a synchronous write port and an asynchronous read of the head address. It has no reset, which keeps pointer/flag control in uart_rx_fifo.

Test Plan:
- Reset, then write 0x41,0x42,0x43 with WE pulses → EMPTY=0 one cycle after the first WE, COUNT=3; three RE pulses return 0x41,0x42,0x43, then EMPTY=1, COUNT=0.
- Fill 16 entries, then WE with 0x99 → FULL=1, OVERRUN=1, COUNT=16, head still the first entry; OVR_CLR → OVERRUN=0.
- At FULL, WE and RE in the same cycle with 0x55 → COUNT stays 16, OVERRUN=0; after 16 pops, the last byte read is 0x55.
- Write 0x10 with FE_IN=1, then 0x11 clean → FIFOERR=1; first RE pops FE=1 and FIFOERR=0 the next cycle; head 0x11 shows FE=0.
- With 5 entries and OVERRUN=1, pulse CLEAR while WE=1 → COUNT=0, EMPTY=1, FIFOERR=0, OVERRUN stays 1; the written byte is discarded.
- (TRIGGER_EN) RCLVL=01: TRIGGER=0 at COUNT=3, TRIGGER=1 at COUNT=4, back to 0 after one RE.
